prefix_adder_error_sweeper: RTL and testbench

- Sequencing controller for an exhaustive error-characterisation sweep of one WIDTH-bit approximate parallel-prefix adder, such as the 8-bit Kogge-Stone variants.
- Drives every operand pair (A,B) into the adder under test and samples its (WIDTH+1)-bit sum after a fixed latency.
- Compares each sample against the exact sum and accumulates error statistics: error count, maximum error distance, summed error distance.
- Sits beside the adder in the characterisation harness. The adder is external; only its operand and sum buses connect here.

---
 rtl/prefix_adder_error_sweeper_if.sv | 12 +
 rtl/prefix_adder_error_sweeper.sv | 171 +++++++++++++++++
 tb/tb_prefix_adder_error_sweeper.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/prefix_adder_error_sweeper_if.sv
// Operand/result bus between the error sweeper and the adder under test.
interface prefix_adder_error_sweeper_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic [WIDTH:0]   dut_sum;

  modport master (output op_a, output op_b, output op_valid, input dut_sum);
  modport slave  (input op_a, input op_b, input op_valid, output dut_sum);
endinterface

// File: rtl/prefix_adder_error_sweeper.sv
// Exhaustive operand sweep of an approximate adder, accumulating error count,
// maximum error distance and summed error distance against the exact sum.
module prefix_adder_error_sweeper #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SUM_LAT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  prefix_adder_error_sweeper_if.master  bus,
  output logic [2*WIDTH:0]              err_count,
  output logic [WIDTH:0]                max_ed,
  output logic [3*WIDTH+1:0]            sum_ed
);
  localparam int unsigned EW = 2*WIDTH + 1;
  localparam int unsigned SW = 3*WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_valid_q, op_valid_d;
  logic [2:0]       drain_q, drain_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [EW-1:0]    err_q, err_d;
  logic [WIDTH:0]   max_q, max_d;
  logic [SW-1:0]    sum_q, sum_d;

  logic             abort_take;
  logic             tap_valid;
  logic [WIDTH:0]   tap_exact, exact_now, ed;

  assign exact_now  = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign abort_take = abort && (state_q == S_RUN || state_q == S_DRAIN);

  // Delay line realigns the exact sum with the adder's result latency.
  if (SUM_LAT == 0) begin : g_no_dl
    assign tap_valid = op_valid_q;
    assign tap_exact = exact_now;
  end else begin : g_dl
    logic [SUM_LAT-1:0] dv_q, dv_d;
    logic [WIDTH:0]     de_q [SUM_LAT];
    logic [WIDTH:0]     de_d [SUM_LAT];

    always_comb begin
      dv_d    = '0;
      dv_d[0] = op_valid_q;
      de_d[0] = exact_now;
      for (int unsigned i = 1; i < SUM_LAT; i++) begin
        dv_d[i] = dv_q[i-1];
        de_d[i] = de_q[i-1];
      end
      if (abort_take) dv_d = '0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dv_q <= '0;
        for (int unsigned i = 0; i < SUM_LAT; i++) de_q[i] <= '0;
      end else begin
        dv_q <= dv_d;
        for (int unsigned i = 0; i < SUM_LAT; i++) de_q[i] <= de_d[i];
      end
    end

    assign tap_valid = dv_q[SUM_LAT-1];
    assign tap_exact = de_q[SUM_LAT-1];
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    drain_d    = drain_q;
    err_d      = err_q;
    max_d      = max_q;
    sum_d      = sum_q;

    ed = (bus.dut_sum >= tap_exact) ? (bus.dut_sum - tap_exact) : (tap_exact - bus.dut_sum);

    // The pair on the tap at an abort edge counts as in flight and is dropped.
    if (tap_valid && !abort_take) begin
      if (ed != '0) begin
        err_d = err_q + EW'(1);
        sum_d = sum_q + SW'(ed);
      end
      if (ed > max_q) max_d = ed;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          op_a_d     = '0;
          op_b_d     = '0;
          op_valid_d = 1'b1;
          err_d      = '0;
          max_d      = '0;
          sum_d      = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d    = S_IDLE;
          op_valid_d = 1'b0;
        end else if ((&op_a_q) && (&op_b_q)) begin
          state_d    = S_DRAIN;
          op_valid_d = 1'b0;
          op_a_d     = '0;
          op_b_d     = '0;
          drain_d    = '0;
        end else begin
          op_b_d = op_b_q + WIDTH'(1);
          if (&op_b_q) op_a_d = op_a_q + WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (drain_q == 3'(SUM_LAT)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
    end
  end

  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_valid = op_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_count    = err_q;
  assign max_ed       = max_q;
  assign sum_ed       = sum_q;
endmodule

// File: tb/tb_prefix_adder_error_sweeper.sv
// Bench: three sweeper instances (W2/L0, W8/L0, W4/L2) against small adder models.
module tb_prefix_adder_error_sweeper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v, abort_v;
  logic       bad2;

  prefix_adder_error_sweeper_if #(.WIDTH(2)) bus2 ();
  prefix_adder_error_sweeper_if #(.WIDTH(8)) bus8 ();
  prefix_adder_error_sweeper_if #(.WIDTH(4)) bus4 ();

  logic        busy2, done2, busy8, done8, busy4, done4;
  logic [4:0]  err2;  logic [2:0] max2;  logic [7:0]  sum2;
  logic [16:0] err8;  logic [8:0] max8;  logic [25:0] sum8;
  logic [8:0]  err4;  logic [4:0] max4;  logic [13:0] sum4;

  prefix_adder_error_sweeper #(.WIDTH(2), .SUM_LAT(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .busy(busy2), .done(done2),
    .bus(bus2), .err_count(err2), .max_ed(max2), .sum_ed(sum2));
  prefix_adder_error_sweeper #(.WIDTH(8), .SUM_LAT(0)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .busy(busy8), .done(done8),
    .bus(bus8), .err_count(err8), .max_ed(max8), .sum_ed(sum8));
  prefix_adder_error_sweeper #(.WIDTH(4), .SUM_LAT(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .busy(busy4), .done(done4),
    .bus(bus4), .err_count(err4), .max_ed(max4), .sum_ed(sum4));

  // W2: exact, or exact with bit 0 flipped (error distance 1 on every pair)
  assign bus2.dut_sum = ({1'b0, bus2.op_a} + {1'b0, bus2.op_b}) ^ {2'b00, bad2};
  // W8: exact with SUM[0] forced to 0
  logic [8:0] s8;
  assign s8 = {1'b0, bus8.op_a} + {1'b0, bus8.op_b};
  assign bus8.dut_sum = {s8[8:1], 1'b0};
  // W4: off by exactly 3 (kept in range), registered twice
  logic [4:0] s4, p1, p2;
  assign s4 = {1'b0, bus4.op_a} + {1'b0, bus4.op_b};
  always @(posedge clk) begin
    p1 <= (s4 > 5'd28) ? s4 - 5'd3 : s4 + 5'd3;
    p2 <= p1;
  end
  assign bus4.dut_sum = p2;

  int     sel;
  logic   v_busy, v_done, v_valid;
  longint v_a, v_b, v_err, v_max, v_sum;
  always_comb begin
    v_busy = busy2; v_done = done2; v_valid = bus2.op_valid;
    v_a = longint'(bus2.op_a); v_b = longint'(bus2.op_b);
    v_err = longint'(err2); v_max = longint'(max2); v_sum = longint'(sum2);
    if (sel == 1) begin
      v_busy = busy8; v_done = done8; v_valid = bus8.op_valid;
      v_a = longint'(bus8.op_a); v_b = longint'(bus8.op_b);
      v_err = longint'(err8); v_max = longint'(max8); v_sum = longint'(sum8);
    end else if (sel == 2) begin
      v_busy = busy4; v_done = done4; v_valid = bus4.op_valid;
      v_a = longint'(bus4.op_a); v_b = longint'(bus4.op_b);
      v_err = longint'(err4); v_max = longint'(max4); v_sum = longint'(sum4);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string  name;
    int     sel;
    int     w;
    logic   bad;
    int     restart_at;
    longint err;
    longint mx;
    longint sm;
    int     lat;
  } vec_t;

  task automatic run_sweep(input vec_t v);
    longint exp_q[$];
    longint n, got, want;
    int n_valid, last_valid, done_edge, done_cnt;
    n = longint'(1) << (2 * v.w);
    for (longint a = 0; a < (longint'(1) << v.w); a++)
      for (longint b = 0; b < (longint'(1) << v.w); b++)
        exp_q.push_back((a << v.w) | b);
    bad2 = v.bad;
    sel  = v.sel;
    n_valid = 0; last_valid = -1; done_edge = -1; done_cnt = 0;
    start_v[v.sel] = 1'b1;
    for (int e = 0; e <= v.lat + 3; e++) begin
      tick();
      start_v[v.sel] = (e == v.restart_at);
      if (e == 0) check({v.name, " busy after start"}, longint'(v_busy), 1);
      if (v_valid) begin
        n_valid++;
        last_valid = e;
        got = (v_a << v.w) | v_b;
        if (exp_q.size() == 0) check({v.name, " extra pair"}, got, -1);
        else begin
          want = exp_q.pop_front();
          check({v.name, " pair"}, got, want);
        end
      end
      if (v_done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
    end
    start_v[v.sel] = 1'b0;
    check({v.name, " valid cycles"}, longint'(n_valid), n);
    check({v.name, " last valid edge"}, longint'(last_valid), n - 1);
    check({v.name, " done edge"}, longint'(done_edge), longint'(v.lat));
    check({v.name, " done pulses"}, longint'(done_cnt), 1);
    check({v.name, " busy at end"}, longint'(v_busy), 0);
    check({v.name, " err_count"}, v_err, v.err);
    check({v.name, " max_ed"}, v_max, v.mx);
    check({v.name, " sum_ed"}, v_sum, v.sm);
  endtask

  vec_t tbl[5];
  int   dcount;

  initial begin
    tbl[0] = '{name:"w2_exact",   sel:0, w:2, bad:1'b0, restart_at:-1, err:0,     mx:0, sm:0,     lat:17};
    tbl[1] = '{name:"w2_flip0",   sel:0, w:2, bad:1'b1, restart_at:-1, err:16,    mx:1, sm:16,    lat:17};
    tbl[2] = '{name:"w2_restart", sel:0, w:2, bad:1'b0, restart_at:4,  err:0,     mx:0, sm:0,     lat:17};
    tbl[3] = '{name:"w4_plus3",   sel:2, w:4, bad:1'b0, restart_at:-1, err:256,   mx:3, sm:768,   lat:259};
    tbl[4] = '{name:"w8_bit0",    sel:1, w:8, bad:1'b0, restart_at:-1, err:32768, mx:1, sm:32768, lat:65537};

    rst = 1'b1; start_v = '0; abort_v = '0; bad2 = 1'b0; sel = 0;
    tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset op_valid", longint'(v_valid), 0);
      check("reset busy", longint'(v_busy), 0);
      check("reset done", longint'(v_done), 0);
      check("reset op_a", v_a, 0);
      check("reset op_b", v_b, 0);
      check("reset err_count", v_err, 0);
      check("reset max_ed", v_max, 0);
      check("reset sum_ed", v_sum, 0);
    end

    // abort on the 6th RUN cycle
    sel = 0; bad2 = 1'b0;
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort busy before", longint'(v_busy), 1);
    abort_v[0] = 1'b1; tick(); abort_v[0] = 1'b0;
    check("abort busy after", longint'(v_busy), 0);
    check("abort op_valid after", longint'(v_valid), 0);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (v_done) dcount++;
      tick();
    end
    check("abort no done", longint'(dcount), 0);
    check("abort err_count", v_err, 0);

    // start and abort together in IDLE: start wins
    start_v[0] = 1'b1; abort_v[0] = 1'b1; tick();
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    check("start beats abort", longint'(v_busy), 1);
    abort_v[0] = 1'b1; tick(); abort_v[0] = 1'b0;
    check("second abort busy", longint'(v_busy), 0);
    tick();

    for (int t = 0; t < 5; t++) begin
      run_sweep(tbl[t]);
      tick();
    end

    // rst mid-RUN with an erroring model: partial stats visible, then cleared
    sel = 0; bad2 = 1'b1;
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midrun err_count", v_err, 7);
    check("midrun sum_ed", v_sum, 7);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst op_valid", longint'(v_valid), 0);
    check("rst busy", longint'(v_busy), 0);
    check("rst err_count", v_err, 0);
    check("rst max_ed", v_max, 0);
    check("rst sum_ed", v_sum, 0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (v_done || v_valid) dcount++;
      tick();
    end
    check("rst no activity", longint'(dcount), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
